// File: rtl/seq_shift_rotate_unit.sv
// Multi-cycle shift/rotate unit: applies one binary stage (16,8,4,2,1) per clock.
// Uses a start/busy/done handshake, and the result is held until the next op completes.
module seq_shift_rotate_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2:0]             mode,
    input  logic [DATA_WIDTH-1:0]  data_a,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  result
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [2:0]             cnt_r;
    logic [2:0]             mode_r;
    logic [SHAMT_WIDTH-1:0] shamt_r;
    logic [DATA_WIDTH-1:0]  work_r;
    logic [DATA_WIDTH-1:0]  stage_s;
    logic                   shamt_bit_s;
    logic                   accept_s;
    logic                   last_stage_s;
    logic                   busy_r;
    logic                   done_r;
    logic [DATA_WIDTH-1:0]  result_r;

    // One log-step stage: move the word by 2^k in the direction the mode selects.
    function automatic logic [31:0] shift_stage(input logic [31:0] d,
                                                input logic [2:0]  m,
                                                input logic [2:0]  k);
        logic [5:0]  amt;
        logic [31:0] r;
        amt = 6'd1 << k;
        case (m)
            3'd0:    r = d << amt;
            3'd1:    r = (d << amt) | (d >> (6'd32 - amt));
            3'd2:    r = d >> amt;
            3'd3:    r = 32'($signed(d) >>> amt);
            3'd4:    r = (d >> amt) | (d << (6'd32 - amt));
            default: r = d;
        endcase
        return r;
    endfunction

    assign accept_s     = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign last_stage_s = (state_r == ST_RUN) && (cnt_r == 3'd0);

    // Next-state logic and the current stage's datapath value.
    always_comb begin
        next_state_s = state_r;
        shamt_bit_s  = 1'b0;
        stage_s      = work_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_RUN;
                else       next_state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (cnt_r == 3'd0) next_state_s = ST_DONE;
                else               next_state_s = ST_RUN;
            end
            ST_DONE: begin
                if (start) next_state_s = ST_RUN;
                else       next_state_s = ST_IDLE;
            end
            default: next_state_s = ST_IDLE;
        endcase
        case (cnt_r)
            3'd0:    shamt_bit_s = shamt_r[0];
            3'd1:    shamt_bit_s = shamt_r[1];
            3'd2:    shamt_bit_s = shamt_r[2];
            3'd3:    shamt_bit_s = shamt_r[3];
            3'd4:    shamt_bit_s = shamt_r[4];
            default: shamt_bit_s = 1'b0;
        endcase
        if (shamt_bit_s) stage_s = shift_stage(work_r, mode_r, cnt_r);
        else             stage_s = work_r;
    end

    // FSM state register and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == ST_RUN);
            done_r  <= (next_state_s == ST_DONE);
        end
    end

    // Operand latch, working register and stage counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= 3'd4;
            mode_r  <= 3'd0;
            shamt_r <= '0;
            work_r  <= '0;
        end else if (accept_s) begin
            cnt_r   <= 3'd4;
            mode_r  <= mode;
            shamt_r <= shamt;
            work_r  <= data_a;
        end else if (state_r == ST_RUN) begin
            // Rearm to 4 after the final stage so the counter never wraps.
            cnt_r   <= (cnt_r == 3'd0) ? 3'd4 : (cnt_r - 3'd1);
            work_r  <= stage_s;
        end else begin
            cnt_r   <= cnt_r;
            work_r  <= work_r;
        end
    end

    // Result register: loaded only as the last stage completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_r <= '0;
        end else if (last_stage_s) begin
            result_r <= stage_s;
        end else begin
            result_r <= result_r;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule
